cluster_event_rx: RTL and testbench
===================================

// Module: cluster_event_rx
// PURPOSE
// - Cluster-side receiver of the SoC->cluster event bus (token ring: write token, read pointer, slot data).
// - Synchronises the SoC write token into the cluster clock and pops event slots in ring order.
// - Returns a one-bit-per-event read pointer to the SoC side.
// - Presents events as a valid/ready stream to the cluster event unit.
// PARAMETERS
// BUFFER_WIDTH  8  number of ring slots; token and pointer width
// EVNT_WIDTH    8  event ID width per slot
// PORTS
// clk_i               in   1                        cluster clock; only clock of the block
// rst_i               in   1                        reset, synchronous, active-high
// events_wt_i         in   BUFFER_WIDTH             SoC write token, asynchronous; bit i toggles when slot i is written
// events_da_i         in   BUFFER_WIDTH*EVNT_WIDTH  slot data, slot i at [i*EVNT_WIDTH +: EVNT_WIDTH]; async, quasi-static
// events_rp_o         out  BUFFER_WIDTH             read pointer to SoC; bit i toggles when slot i is consumed
// evt_valid_o         out  1                        output event valid
// evt_data_o          out  EVNT_WIDTH               output event ID
// evt_ready_i         in   1                        consumer accepts evt_data_o
// evt_pending_o       out  $clog2(BUFFER_WIDTH+1)   occupied slots not yet loaded into the output register
// BEHAVIOUR
// - Sync: 2-flop synchroniser per bit, wt_s = sync(events_wt_i). Data is not synchronised.
//   Sender holds slot i data stable from its wt[i] toggle until it sees rp[i] toggle back.
// - Slot occupancy: occ[i] = wt_s[i] ^ rp_q[i]. evt_pending_o = popcount(occ), combinational from registers.
// - rd_idx: $clog2(BUFFER_WIDTH)-bit pointer to the next slot. Slots are consumed strictly in ring order.
//   rd_idx increments mod BUFFER_WIDTH. Non-power-of-2 depth wraps explicitly from BUFFER_WIDTH-1 to 0.
// - Load condition: load = occ[rd_idx] & (~evt_valid_o | evt_ready_i).
//   On load: evt_data_o <= slot[rd_idx]; evt_valid_o <= 1; rp_q[rd_idx] toggles; rd_idx advances.
//   The slot is freed as soon as it is captured, not when the consumer accepts it.
// - Pop: if evt_valid_o & evt_ready_i & ~load, then evt_valid_o <= 0.
//   Simultaneous pop and load keeps evt_valid_o = 1 with the new data. Throughput is 1 event/cycle.
// - Output register: evt_data_o stays stable while evt_valid_o=1 and evt_ready_i=0.
//   evt_valid_o never drops without a handshake.
// - Latency: wt toggle sampled at edge 0 -> wt_s at edge 2 -> load at edge 3, so evt_valid_o=1 after edge 3.
//   events_rp_o toggles on the same edge 3.
// - events_rp_o = rp_q, driven directly from a flop (glitch-free for the SoC-side synchroniser).
// - Full ring (all occ=1): no special case; the sender stalls on its own token/pointer compare.
// - Empty (occ[rd_idx]=0): no load. Occupied slots other than rd_idx are ignored until rd_idx reaches them.
// - Reset values (rst_i=1 at a clock edge): wt_s and sync stage 1 = 0, rp_q = 0, rd_idx = 0,
//   evt_valid_o = 0, evt_data_o = 0, evt_pending_o = 0 (from the reset state).
// - Reset mid-operation: any in-flight event is discarded. SoC side and cluster side are reset jointly.
//   A slot with wt=1 after a one-sided reset is treated as a valid event, by design.
// - No combinational path from events_wt_i or events_da_i to any output. evt_ready_i affects only next state.
// TESTING
// - Single event: toggle wt[0], da slot0=8'h2A, ready=1 -> evt_valid_o=1 with data 8'h2A
//   exactly 3 cycles later; rp_o[0]=1 on that edge.
// - Backpressure: ready=0; write slots 0..7 (IDs 1..8) -> evt_valid_o=1, data=1, rp_o=8'h01, pending=7.
//   Raise ready -> IDs 1..8 out on consecutive cycles; rp_o ends at 8'hFF; pending=0.
// - Wrap-around: stream 20 events (IDs 0..19) with the sender respecting rp.
//   -> all 20 arrive in order, no duplicates; rd_idx wraps twice; final rp_o=8'h0F.
// - Simultaneous: evt_valid_o=1, ready=1, slot at rd_idx occupied -> same-edge pop+load;
//   evt_valid_o stays 1 and data changes to the new ID.
// - Reset mid-op: 3 slots pending with ready=0; assert rst_i for 1 cycle on both sides
//   -> next cycle evt_valid_o=0, rp_o=0, pending=0; a new event with ID 8'h55 arrives after 3 cycles.
// - Stall stability: ready=0 for 10 cycles while new events arrive -> evt_data_o unchanged; pending counts up.

Source files
------------

// File: rtl/cluster_event_rx.sv
`default_nettype none
// ============================================================================
// Module  : cluster_event_rx
// Brief   : Cluster-side receiver for the SoC->cluster token-ring event bus.
//           It synchronises the write token, pops slots in ring order, returns
//           the read pointer to the SoC and drives a valid/ready event stream.
// Revision: 1.0 - initial release
// ============================================================================
module cluster_event_rx #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [BUFFER_WIDTH-1:0]            events_wt_i,
    input  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_i,
    output logic [BUFFER_WIDTH-1:0]            events_rp_o,
    output logic                               evt_valid_o,
    output logic [EVNT_WIDTH-1:0]              evt_data_o,
    input  logic                               evt_ready_i,
    output logic [$clog2(BUFFER_WIDTH+1)-1:0]  evt_pending_o
);

    localparam int c_IDX_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
    localparam int c_CNT_W = $clog2(BUFFER_WIDTH + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BUFFER_WIDTH - 1);

    logic [BUFFER_WIDTH-1:0] r_wt_meta;
    logic [BUFFER_WIDTH-1:0] r_wt_sync;
    logic [BUFFER_WIDTH-1:0] r_rp;
    logic [c_IDX_W-1:0]      r_rd_idx;
    logic                    r_valid;
    logic [EVNT_WIDTH-1:0]   r_data;

    logic [EVNT_WIDTH-1:0]   w_slot [BUFFER_WIDTH];
    logic [BUFFER_WIDTH-1:0] w_occ;
    logic                    w_load;
    logic [BUFFER_WIDTH-1:0] w_rp_toggle;
    logic [c_IDX_W-1:0]      w_idx_next;
    logic [c_CNT_W-1:0]      w_pending;

    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_slot
            assign w_slot[gi] = events_da_i[gi*EVNT_WIDTH +: EVNT_WIDTH];
        end
    endgenerate

    // A slot is occupied while the synchronised write token differs from our pointer.
    assign w_occ       = r_wt_sync ^ r_rp;
    assign w_load      = w_occ[r_rd_idx] & (~r_valid | evt_ready_i);
    assign w_rp_toggle = w_load ? (BUFFER_WIDTH'(1) << r_rd_idx) : '0;
    assign w_idx_next  = (r_rd_idx == c_LAST_IDX) ? '0 : r_rd_idx + 1'b1;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < BUFFER_WIDTH; i++) begin
            w_pending = w_pending + c_CNT_W'(w_occ[i]);
        end
    end

    // Slot data is only sampled once its token has crossed both sync stages,
    // by which time the sender guarantees it is stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wt_meta <= '0;
            r_wt_sync <= '0;
            r_rp      <= '0;
            r_rd_idx  <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            r_wt_meta <= events_wt_i;
            r_wt_sync <= r_wt_meta;
            r_rp      <= r_rp ^ w_rp_toggle;
            if (w_load) begin
                r_data   <= w_slot[r_rd_idx];
                r_valid  <= 1'b1;
                r_rd_idx <= w_idx_next;
            end else if (r_valid && evt_ready_i) begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign events_rp_o   = r_rp;
    assign evt_valid_o   = r_valid;
    assign evt_data_o    = r_data;
    assign evt_pending_o = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_cluster_event_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_cluster_event_rx
// Brief   : Self-checking bench for cluster_event_rx with a SoC-side sender
//           model and an in-order scoreboard of expected event IDs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cluster_event_rx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  wt;
    logic [63:0] da;
    logic [7:0]  events_rp_o;
    logic        evt_valid_o;
    logic [7:0]  evt_data_o;
    logic        evt_ready_i;
    logic [3:0]  evt_pending_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pops     = 0;
    int          wr_idx   = 0;
    logic [7:0]  exp_q [$];

    typedef struct {
        logic [7:0] id;
        logic [7:0] exp_rp;
    } vec_t;
    vec_t vecs [4];

    cluster_event_rx #(
        .BUFFER_WIDTH (8),
        .EVNT_WIDTH   (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .events_wt_i   (wt),
        .events_da_i   (da),
        .events_rp_o   (events_rp_o),
        .evt_valid_o   (evt_valid_o),
        .evt_data_o    (evt_data_o),
        .evt_ready_i   (evt_ready_i),
        .evt_pending_o (evt_pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sender model: writes the next ring slot once the receiver has freed it.
    task automatic send(input logic [7:0] id);
        int guard = 0;
        while (wt[wr_idx] != events_rp_o[wr_idx] && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL send_timeout: slot %0d still busy, rp=0x%0h", wr_idx, events_rp_o);
        end
        da[wr_idx*8 +: 8] = id;
        wt[wr_idx]        = ~wt[wr_idx];
        exp_q.push_back(id);
        wr_idx = (wr_idx == 7) ? 0 : wr_idx + 1;
    endtask

    task automatic do_reset(input int cycles);
        rst_i  = 1'b1;
        wt     = '0;
        da     = '0;
        wr_idx = 0;
        exp_q.delete();
        repeat (cycles) step();
        rst_i  = 1'b0;
    endtask

    // Sends one event with ready high and checks the exact 3-edge latency.
    task automatic single(input logic [7:0] id, input logic [7:0] exp_rp);
        send(id);
        step();
        check("lat_edge1_valid", evt_valid_o, 0);
        step();
        check("lat_edge2_valid", evt_valid_o, 0);
        step();
        check("lat_edge3_valid", evt_valid_o, 1);
        check("lat_edge3_data", evt_data_o, id);
        check("lat_edge3_rp", events_rp_o, exp_rp);
        step();
        check("after_pop_valid", evt_valid_o, 0);
    endtask

    // Scoreboard: a handshake completes at the next posedge when valid&ready mid-cycle.
    always @(negedge clk) begin
        if (!rst_i && evt_valid_o && evt_ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no event", evt_data_o);
            end else begin
                check("pop_data", evt_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        int prev_pend;
        vecs[0] = '{id: 8'h2A, exp_rp: 8'h01};
        vecs[1] = '{id: 8'h3C, exp_rp: 8'h03};
        vecs[2] = '{id: 8'hFF, exp_rp: 8'h07};
        vecs[3] = '{id: 8'h00, exp_rp: 8'h0F};

        evt_ready_i = 1'b0;
        do_reset(2);
        check("reset_valid", evt_valid_o, 0);
        check("reset_data", evt_data_o, 0);
        check("reset_rp", events_rp_o, 0);
        check("reset_pending", evt_pending_o, 0);

        evt_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) single(vecs[i].id, vecs[i].exp_rp);

        // Backpressure with a full ring.
        evt_ready_i = 1'b0;
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            send(8'(i + 1));
            step();
        end
        repeat (5) step();
        check("bp_valid", evt_valid_o, 1);
        check("bp_data", evt_data_o, 8'h01);
        check("bp_rp", events_rp_o, 8'h01);
        check("bp_pending", evt_pending_o, 7);
        pops = 0;
        evt_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_stream_valid", evt_valid_o, 1);
            step();
        end
        check("bp_end_valid", evt_valid_o, 0);
        check("bp_end_rp", events_rp_o, 8'hFF);
        check("bp_end_pending", evt_pending_o, 0);
        check("bp_pops", pops, 8);

        // Wrap-around stream of 20 events.
        do_reset(1);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            send(8'(i));
            step();
        end
        repeat (8) step();
        check("wrap_pops", pops, 20);
        check("wrap_rp", events_rp_o, 8'h0F);
        check("wrap_pending", evt_pending_o, 0);
        check("wrap_q_empty", exp_q.size(), 0);

        // Same-edge pop and load.
        evt_ready_i = 1'b0;
        do_reset(1);
        send(8'h11);
        step();
        send(8'h22);
        repeat (6) step();
        check("simul_pre_data", evt_data_o, 8'h11);
        check("simul_pre_pending", evt_pending_o, 1);
        evt_ready_i = 1'b1;
        step();
        check("simul_valid", evt_valid_o, 1);
        check("simul_data", evt_data_o, 8'h22);
        step();
        check("simul_drain_valid", evt_valid_o, 0);

        // Reset in the middle of operation.
        evt_ready_i = 1'b0;
        do_reset(1);
        send(8'h31);
        step();
        send(8'h32);
        step();
        send(8'h33);
        repeat (6) step();
        check("midrst_pre_valid", evt_valid_o, 1);
        check("midrst_pre_pending", evt_pending_o, 2);
        do_reset(1);
        check("midrst_valid", evt_valid_o, 0);
        check("midrst_rp", events_rp_o, 0);
        check("midrst_pending", evt_pending_o, 0);
        evt_ready_i = 1'b1;
        single(8'h55, 8'h01);

        // Output must hold under a long stall while new events keep arriving.
        evt_ready_i = 1'b0;
        do_reset(1);
        send(8'h70);
        repeat (5) step();
        check("stall_first_valid", evt_valid_o, 1);
        prev_pend = evt_pending_o;
        for (int c = 0; c < 10; c++) begin
            if (c < 7) send(8'(8'h71 + c));
            step();
            check("stall_data", evt_data_o, 8'h70);
            check("stall_valid", evt_valid_o, 1);
            check("stall_pend_monotonic", (int'(evt_pending_o) >= prev_pend), 1);
            prev_pend = evt_pending_o;
        end
        check("stall_pending", evt_pending_o, 7);
        pops = 0;
        evt_ready_i = 1'b1;
        repeat (12) step();
        check("stall_pops", pops, 8);
        check("stall_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
